hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order pipeline, replacing the fixed two-stage destination compare. It tracks in-flight register writes in an internal DEPTH-entry scoreboard shift register advancing alongside the post-ID pipeline stages. It resolves each ID-stage source operand to one of three outcomes: forward from a stage, stall, or read the register file. It also inserts bubbles on freeze and branch flush, and keeps a saturating stall counter for performance monitoring.

## Interface
- REG_AW, 5, register address width
- DEPTH, 3, tracked stages after ID (entry 0 = EXE, DEPTH-1 = WB)
- LOAD_LAT, 1, stages a load needs before its data is forwardable (entry index >= LOAD_LAT)
- SEL_W, $clog2(DEPTH+1), forwarding select width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; **one clock; reset is synchronous and active-low**
- id_valid  in  1  ID holds a real instruction
- src1  in  REG_AW  first source register
- src2  in  REG_AW  second source register
- src2_used  in  1  src2 is read (isSrc2)
- id_dest  in  REG_AW  destination of ID instruction
- id_wb_en  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- br_taken  in  1  branch resolved taken in EXE this cycle
- freez  out  1  hold PC and IF/ID register
- flush  out  1  squash IF/ID contents
- fwd_sel1  out  SEL_W  0 = register file, k = entry k-1
- fwd_sel2  out  SEL_W  as fwd_sel1, for src2
- stall_cnt  out  CNT_W  cycles with freez high, saturating

## Operation
- Entry fields: valid, wb_en, is_load, dest.
- Each posedge, entries shift (entry i to i+1, entry DEPTH-1 discarded).
- Entry 0 loads from ID when id_valid && !freez && !br_taken; otherwise it loads a bubble (valid=0).
- Match for a source: entry valid && wb_en && dest == src && src != 0.
- The lowest-index (youngest) matching entry wins; older matches are ignored.
- src2 is evaluated only when src2_used=1; otherwise fwd_sel2=0 and src2 causes no stall.
- Winning entry k is ready if !is_load || k >= LOAD_LAT.
- Ready winner: fwd_selN = k+1, no stall.
- Not ready: stall.
- No match: fwd_selN = 0.
- freez = id_valid && (stall on src1 || stall on src2) && !br_taken.
- flush = br_taken. br_taken overrides freez, because the ID instruction is discarded anyway.
- stall_cnt increments on each cycle with freez=1 and holds at all-ones.
- Entries shifted out of DEPTH-1 are treated as already written to the register file. The register file must be write-before-read, or DEPTH must cover the WB stage.

## Timing
- freez, flush and fwd_sel1/2 are combinational from inputs and scoreboard state, with zero-cycle latency.
- Scoreboard and stall_cnt update on the rising clk edge.
- Reset (rst=0 at posedge) clears all entries and sets stall_cnt=0, giving freez=0, flush=0 (with br_taken=0), fwd_sel1=fwd_sel2=0.
- Reset mid-stall clears the stall on the next cycle.
- Load-use with LOAD_LAT=1 and the load in entry 0:
  - one-cycle freez;
  - next cycle the load is in entry 1 and fwd_sel = 2.
- A stall persists while the winning entry stays unready. Bubbles inserted by freez never match.
- Simultaneous br_taken and hazard: flush=1, freez=0, and a bubble enters entry 0.

## Configuration
- HAZARD_FORWARD_EN defined:
  - forwarding active as described;
  - stalls occur only on unready loads.
- HAZARD_FORWARD_EN undefined:
  - fwd_sel1/2 are tied to 0;
  - any match in any entry stalls (legacy full-interlock behaviour);
  - stall_cnt still operates.

## Test plan
- Reset with rst=0 for 2 cycles, then an ALU write to r3 issued -> freez=0, fwd_sel=0, stall_cnt=0 before the write.
- ALU "r3" then a consumer of src1=r3 -> forward on: fwd_sel1=1, freez=0; forward off: freez=1 for 3 cycles (DEPTH=3).
- Load r5 then src2=r5, src2_used=1 -> freez=1 for exactly 1 cycle, then fwd_sel2=2, stall_cnt=1.
- Writes to r7 in entries 0 and 2, consumer reads r7 -> fwd_sel1=1 (youngest wins).
- Load-use hazard with br_taken=1 the same cycle -> flush=1, freez=0, entry 0 bubble, stall_cnt unchanged.
- src=r0 with a matching r0 write in flight -> no stall, fwd_sel=0; forcing 2^CNT_W+5 stall cycles -> stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write scoreboard resolving ID operands to forward/stall/regfile.
// Define HAZARD_FORWARD_EN for forwarding; otherwise any in-flight match interlocks.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1),
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              br_taken,
    output logic              freez,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic [DEPTH-1:0]  e_valid, e_wb, e_load;
    logic [REG_AW-1:0] e_dest [DEPTH];
    logic              stall1, stall2;

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        stall1   = 1'b0;
        stall2   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (e_valid[i] && e_wb[i] && e_dest[i] == src1 && src1 != '0) begin
`ifdef HAZARD_FORWARD_EN
                stall1   = e_load[i] && i < LOAD_LAT;
                fwd_sel1 = stall1 ? '0 : SEL_W'(i + 1);
`else
                stall1   = 1'b1;
`endif
            end
            if (src2_used && e_valid[i] && e_wb[i] && e_dest[i] == src2 && src2 != '0) begin
`ifdef HAZARD_FORWARD_EN
                stall2   = e_load[i] && i < LOAD_LAT;
                fwd_sel2 = stall2 ? '0 : SEL_W'(i + 1);
`else
                stall2   = 1'b1;
`endif
            end
        end
    end

`ifndef HAZARD_FORWARD_EN
    logic unused_load;
    assign unused_load = ^e_load;
`endif

    assign freez = id_valid && (stall1 || stall2) && !br_taken;
    assign flush = br_taken;

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_valid   <= '0;
            e_wb      <= '0;
            e_load    <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) e_dest[i] <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                e_valid[i] <= e_valid[i-1];
                e_wb[i]    <= e_wb[i-1];
                e_load[i]  <= e_load[i-1];
                e_dest[i]  <= e_dest[i-1];
            end
            e_valid[0] <= id_valid && !freez && !br_taken;
            e_wb[0]    <= id_wb_en;
            e_load[0]  <= id_mem_read;
            e_dest[0]  <= id_dest;
            if (freez && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: queued expected-output scoreboard for hazard_scoreboard.
module tb_hazard_scoreboard;
    localparam int SEL_W = 2;
    localparam int CNT_W = 10;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 0, rst = 0, id_valid = 0, src2_used = 0, id_wb_en = 0, id_mem_read = 0, br_taken = 0;
    logic [4:0] src1 = 0, src2 = 0, id_dest = 0;
    logic freez, flush;
    logic [SEL_W-1:0] fwd_sel1, fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;
    int errors = 0, checks = 0;

    typedef struct {
        string tag;
        logic fz;
        logic fl;
        logic [SEL_W-1:0] s1;
        logic [SEL_W-1:0] s2;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .src2_used(src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .br_taken(br_taken), .freez(freez), .flush(flush),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".freez"}, 32'(freez), 32'(e.fz));
            chk({e.tag, ".flush"}, 32'(flush), 32'(e.fl));
            chk({e.tag, ".sel1"}, 32'(fwd_sel1), 32'(e.s1));
            chk({e.tag, ".sel2"}, 32'(fwd_sel2), 32'(e.s2));
        end
    end

    task automatic drive(input string tag, input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic u, input logic [4:0] d, input logic w, input logic l,
                         input logic br, input logic fz, input logic fl,
                         input logic [SEL_W-1:0] s1, input logic [SEL_W-1:0] s2);
        @(posedge clk);
        #1;
        id_valid = v; src1 = a; src2 = b; src2_used = u;
        id_dest = d; id_wb_en = w; id_mem_read = l; br_taken = br;
        q.push_back('{tag, fz, fl, s1, s2});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic f;
        logic [SEL_W-1:0] s;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        chk("rst.freez", 32'(freez), 0);
        chk("rst.flush", 32'(flush), 0);
        chk("rst.sel1", 32'(fwd_sel1), 0);
        chk("rst.sel2", 32'(fwd_sel2), 0);
        chk("rst.cnt", 32'(stall_cnt), 0);

        drive("alu_r3", 1, 1, 2, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("cnt_pre", 32'(stall_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            f = FWD ? 1'b0 : (i < 3);
            s = (FWD && i < 3) ? SEL_W'(i + 1) : '0;
            drive($sformatf("use_r3_%0d", i), 1, 3, 0, 0, 4, 1, 0, 0, f, 0, s, 0);
        end
        idle(3);
        chk("cnt_alu", 32'(stall_cnt), FWD ? 0 : 3);

        drive("ld_r5", 1, 1, 2, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            f = FWD ? (i == 0) : 1'b1;
            s = (FWD && i > 0) ? SEL_W'(i + 1) : '0;
            drive($sformatf("use_r5_%0d", i), 1, 1, 5, 1, 6, 1, 0, 0, f, 0, 0, s);
        end
        idle(1);
        chk("cnt_load", 32'(stall_cnt), FWD ? 1 : 6);
        idle(2);

        drive("w7a", 1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        drive("w8", 1, 1, 2, 0, 8, 1, 0, 0, 0, 0, 0, 0);
        drive("w7b", 1, 1, 2, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        drive("use_r7", 1, 7, 7, 0, 9, 1, 0, 0, !FWD, 0, FWD ? 2'd1 : 2'd0, 0);
        idle(3);
        chk("cnt_young", 32'(stall_cnt), FWD ? 1 : 7);

        drive("ld_br", 1, 1, 2, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        drive("use_br", 1, 5, 0, 0, 9, 1, 0, 1, 0, 1, 0, 0);
        drive("after_br", 1, 9, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        chk("cnt_br", 32'(stall_cnt), FWD ? 1 : 7);

        drive("ld_r0", 1, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        drive("use_r0", 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        drive("ld_rst", 1, 1, 2, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        drive("use_rst", 1, 5, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0);
        rst = 0;
        drive("post_rst", 1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        rst = 1;
        chk("cnt_rst", 32'(stall_cnt), 0);
        for (int i = 1; i <= 8; i++) begin
            f = FWD ? i[0] : (i % 4 != 0);
            s = (FWD && !i[0]) ? 2'd2 : 2'd0;
            drive($sformatf("self_%0d", i), 1, 5, 0, 0, 5, 1, 1, 0, f, 0, s, 0);
        end
        chk("cnt_self", 32'(stall_cnt), FWD ? 4 : 6);
        repeat (2 * ((1 << CNT_W) + 5)) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(stall_cnt), (1 << CNT_W) - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
